// File: rtl/register_slice_chain.sv
// Cascade of STAGES valid/ready register slices (HALF, FORWARD or FULL skid type)
// with synchronous flush and a registered occupancy count for drain detection.
module register_slice_chain #(
  parameter int    WIDTH_BITS = 8,
  parameter int    STAGES     = 1,
  parameter string MODE       = "FULL",
  localparam int   OCC_BITS   = $clog2(2*STAGES+2)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WIDTH_BITS-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WIDTH_BITS-1:0] output_data,
  output logic [OCC_BITS-1:0]   occupancy
);

  localparam bit IS_HALF = (MODE == "HALF");
  localparam bit IS_FWD  = (MODE == "FORWARD");

  if (STAGES == 0) begin : g_pass
    assign input_ready  = output_ready && !flush;
    assign output_valid = input_valid && !flush;
    assign output_data  = input_data;
    assign occupancy    = '0;
  end else begin : g_chain
    logic [STAGES-1:0]     main_valid_q, main_valid_d;
    logic [STAGES-1:0]     skid_valid_q, skid_valid_d;
    logic [WIDTH_BITS-1:0] main_data_q [STAGES];
    logic [WIDTH_BITS-1:0] main_data_d [STAGES];
    logic [WIDTH_BITS-1:0] skid_data_q [STAGES];
    logic [WIDTH_BITS-1:0] skid_data_d [STAGES];
    logic [OCC_BITS-1:0]   occ_q, occ_d;
    // rdy[k] is the ready seen by stage k's input; rdy[STAGES] is the block output side
    logic [STAGES:0]       rdy;
    logic [STAGES-1:0]     link_valid;
    logic [WIDTH_BITS-1:0] link_data [STAGES];

    always_comb begin
      logic chain;
      logic drain;
      logic accept;
      drain        = 1'b0;
      accept       = 1'b0;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;

      // Ready is built from registered state only, so the FORWARD ripple is a
      // plain OR chain rather than a loop through the stage array.
      chain       = output_ready && !flush;
      rdy[STAGES] = chain;
      for (int k = STAGES-1; k >= 0; k--) begin
        if (IS_HALF)     chain = !main_valid_q[k];
        else if (IS_FWD) chain = !main_valid_q[k] || chain;
        else             chain = !skid_valid_q[k];
        rdy[k] = chain;
      end

      link_valid[0] = input_valid && !flush;
      link_data[0]  = input_data;
      for (int k = 1; k < STAGES; k++) begin
        link_valid[k] = main_valid_q[k-1];
        link_data[k]  = main_data_q[k-1];
      end

      for (int k = 0; k < STAGES; k++) begin
        drain  = main_valid_q[k] && rdy[k+1];
        accept = link_valid[k] && rdy[k];
        if (IS_HALF) begin
          if (drain) main_valid_d[k] = 1'b0;
          if (accept) begin
            main_valid_d[k] = 1'b1;
            main_data_d[k]  = link_data[k];
          end
        end else if (IS_FWD) begin
          if (rdy[k]) begin
            main_valid_d[k] = link_valid[k];
            if (link_valid[k]) main_data_d[k] = link_data[k];
          end
        end else begin
          // accept implies an empty skid, so skid refill and accept never collide
          if (drain) begin
            if (skid_valid_q[k]) begin
              main_data_d[k]  = skid_data_q[k];
              skid_valid_d[k] = 1'b0;
            end else begin
              main_valid_d[k] = accept;
              if (accept) main_data_d[k] = link_data[k];
            end
          end else if (accept) begin
            if (!main_valid_q[k]) begin
              main_valid_d[k] = 1'b1;
              main_data_d[k]  = link_data[k];
            end else begin
              skid_valid_d[k] = 1'b1;
              skid_data_d[k]  = link_data[k];
            end
          end
        end
      end

      if (flush) begin
        main_valid_d = '0;
        skid_valid_d = '0;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
      end

      occ_d = '0;
      for (int k = 0; k < STAGES; k++) begin
        occ_d = occ_d + OCC_BITS'(main_valid_d[k]) + OCC_BITS'(skid_valid_d[k]);
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        main_valid_q <= '0;
        skid_valid_q <= '0;
        occ_q        <= '0;
        for (int k = 0; k < STAGES; k++) begin
          main_data_q[k] <= '0;
          skid_data_q[k] <= '0;
        end
      end else begin
        main_valid_q <= main_valid_d;
        skid_valid_q <= skid_valid_d;
        occ_q        <= occ_d;
        main_data_q  <= main_data_d;
        skid_data_q  <= skid_data_d;
      end
    end

    assign input_ready  = rdy[0] && !flush;
    assign output_valid = main_valid_q[STAGES-1] && !flush;
    assign output_data  = main_data_q[STAGES-1];
    assign occupancy    = occ_q;
  end

endmodule

// File: tb/tb_register_slice_chain.sv
// Directed bench for register_slice_chain: FULL/HALF/FORWARD chains, pass-through,
// back-pressure into skids, flush and mid-burst reset.
module tb_register_slice_chain;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, flush;
  // A: FULL x2   B: HALF x1   C: FORWARD x3   D: pass-through   E: FULL x4
  logic a_iv, a_ir, a_ov, a_or; logic [7:0] a_id, a_od; logic [2:0] a_occ;
  logic b_iv, b_ir, b_ov, b_or; logic [7:0] b_id, b_od; logic [1:0] b_occ;
  logic c_iv, c_ir, c_ov, c_or; logic [7:0] c_id, c_od; logic [2:0] c_occ;
  logic d_iv, d_ir, d_ov, d_or; logic [7:0] d_id, d_od; logic [0:0] d_occ;
  logic e_iv, e_ir, e_ov, e_or; logic [7:0] e_id, e_od; logic [3:0] e_occ;

  int n_vec = 0;
  int n_err = 0;
  int sent, rcvd, first_acc, first_out, last_out, peak;
  logic [7:0] sb[$];

  int t2_ir [4]  = '{1, 0, 1, 0};
  int t2_ov [4]  = '{0, 1, 0, 1};
  int t2_occ[4]  = '{0, 1, 0, 1};
  logic [7:0] t2_beat[2] = '{8'hA5, 8'h5A};
  int t3_ir [13] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
  int t3_occ[13] = '{0, 1, 2, 2, 2, 3, 4, 4, 4, 4, 3, 2, 2};
  int t3_ov [13] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  register_slice_chain #(.WIDTH_BITS(8), .STAGES(2), .MODE("FULL")) u_a (
    .clock(clock), .reset(reset), .flush(flush),
    .input_valid(a_iv), .input_ready(a_ir), .input_data(a_id),
    .output_valid(a_ov), .output_ready(a_or), .output_data(a_od), .occupancy(a_occ));
  register_slice_chain #(.WIDTH_BITS(8), .STAGES(1), .MODE("HALF")) u_b (
    .clock(clock), .reset(reset), .flush(flush),
    .input_valid(b_iv), .input_ready(b_ir), .input_data(b_id),
    .output_valid(b_ov), .output_ready(b_or), .output_data(b_od), .occupancy(b_occ));
  register_slice_chain #(.WIDTH_BITS(8), .STAGES(3), .MODE("FORWARD")) u_c (
    .clock(clock), .reset(reset), .flush(flush),
    .input_valid(c_iv), .input_ready(c_ir), .input_data(c_id),
    .output_valid(c_ov), .output_ready(c_or), .output_data(c_od), .occupancy(c_occ));
  register_slice_chain #(.WIDTH_BITS(8), .STAGES(0), .MODE("FULL")) u_d (
    .clock(clock), .reset(reset), .flush(flush),
    .input_valid(d_iv), .input_ready(d_ir), .input_data(d_id),
    .output_valid(d_ov), .output_ready(d_or), .output_data(d_od), .occupancy(d_occ));
  register_slice_chain #(.WIDTH_BITS(8), .STAGES(4), .MODE("FULL")) u_e (
    .clock(clock), .reset(reset), .flush(flush),
    .input_valid(e_iv), .input_ready(e_ir), .input_data(e_id),
    .output_valid(e_ov), .output_ready(e_or), .output_data(e_od), .occupancy(e_occ));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    {a_iv, b_iv, c_iv, d_iv, e_iv} = '0;
    {a_id, b_id, c_id, d_id, e_id} = '0;
    {a_or, b_or, c_or, d_or, e_or} = '1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_a_ir", 32'(a_ir), 1);   chk("rst_a_ov", 32'(a_ov), 0);
    chk("rst_a_od", 32'(a_od), 0);   chk("rst_a_occ", 32'(a_occ), 0);
    chk("rst_b_ir", 32'(b_ir), 1);   chk("rst_c_ir", 32'(c_ir), 1);
    chk("rst_c_occ", 32'(c_occ), 0); chk("rst_d_ir", 32'(d_ir), 1);
    chk("rst_d_ov", 32'(d_ov), 0);   chk("rst_e_ir", 32'(e_ir), 1);
    chk("rst_e_ov", 32'(e_ov), 0);
    reset = 1'b0;

    // FULL x2 streaming 0x01..0x10 with the consumer always ready
    sent = 0; rcvd = 0; first_acc = -1; first_out = -1; last_out = -1; peak = 0;
    for (int c = 0; c < 60 && rcvd < 16; c++) begin
      @(negedge clock);
      a_or = 1'b1; a_iv = (sent < 16); a_id = 8'(sent + 1);
      #1;
      if (int'(a_occ) > peak) peak = int'(a_occ);
      if (a_iv && a_ir) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      if (a_ov && a_or) begin
        chk("t1_data", 32'(a_od), 32'(rcvd + 1));
        if (first_out < 0) first_out = c;
        last_out = c;
        rcvd++;
      end
    end
    chk("t1_count", 32'(rcvd), 16);
    chk("t1_latency", 32'(first_out - first_acc), 2);
    chk("t1_back_to_back", 32'(last_out - first_out), 15);
    chk("t1_peak_occ", 32'(peak), 2);
    @(negedge clock); a_iv = 1'b0;

    // HALF x1: one beat every two cycles
    sent = 0; rcvd = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      b_iv = 1'b1; b_or = 1'b1; b_id = (sent < 2) ? t2_beat[sent] : 8'h00;
      #1;
      chk("t2_ir", 32'(b_ir), t2_ir[c]);
      chk("t2_ov", 32'(b_ov), t2_ov[c]);
      chk("t2_occ", 32'(b_occ), t2_occ[c]);
      if (b_iv && b_ir) sent++;
      if (b_ov && b_or && rcvd < 2) begin
        chk("t2_data", 32'(b_od), 32'(t2_beat[rcvd]));
        rcvd++;
      end
    end
    @(negedge clock); b_iv = 1'b0;

    // FULL x2 with output_ready low for 5 cycles: skids absorb, then drain in order
    sent = 0; rcvd = 0;
    for (int c = 0; c < 60 && rcvd < 12; c++) begin
      @(negedge clock);
      a_iv = (sent < 12); a_id = 8'(8'h20 + sent); a_or = !(c >= 4 && c <= 8);
      #1;
      if (c < 13) begin
        chk("t3_ir", 32'(a_ir), t3_ir[c]);
        chk("t3_occ", 32'(a_occ), t3_occ[c]);
        chk("t3_ov", 32'(a_ov), t3_ov[c]);
      end
      if (a_ov) chk("t3_data", 32'(a_od), 32'(8'h20 + rcvd));
      if (a_iv && a_ir) sent++;
      if (a_ov && a_or) rcvd++;
    end
    chk("t3_count", 32'(rcvd), 12);

    // Flush with three beats held, then 0x77 must be the next output
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      flush = (c == 5);
      a_iv = (c <= 5) || (c == 7);
      a_id = (c == 7) ? 8'h77 : 8'(8'h40 + c);
      a_or = (c != 4);
      #1;
      case (c)
        5: begin
          chk("t5_flush_ir", 32'(a_ir), 0);
          chk("t5_flush_ov", 32'(a_ov), 0);
          chk("t5_pre_occ", 32'(a_occ), 3);
        end
        6: begin
          chk("t5_occ", 32'(a_occ), 0);
          chk("t5_ov", 32'(a_ov), 0);
          chk("t5_ir", 32'(a_ir), 1);
          chk("t5_data_kept", 32'(a_od), 32'h42);
        end
        7: chk("t5_accept", 32'(a_ir), 1);
        8: chk("t5_no_spurious", 32'(a_ov), 0);
        9: begin
          chk("t5_out_ov", 32'(a_ov), 1);
          chk("t5_out_data", 32'(a_od), 32'h77);
        end
        default: ;
      endcase
    end
    @(negedge clock); flush = 1'b0; a_iv = 1'b0;

    // FORWARD x3 under random valid/ready, 1000 beats against a queue
    sent = 0; rcvd = 0; sb.delete();
    for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
      @(negedge clock);
      c_iv = ($urandom_range(0, 3) != 0) && (sent < 1000);
      c_id = 8'($urandom_range(0, 255));
      c_or = 1'($urandom_range(0, 1));
      #1;
      chk("t4_occ", 32'(c_occ), 32'(sb.size()));
      chk("t4_ready", 32'(c_ir), 32'((sb.size() < 3) || c_or));
      if (c_ov && c_or) begin
        if (sb.size() == 0) chk("t4_spurious", 32'(c_ov), 0);
        else begin
          chk("t4_data", 32'(c_od), 32'(sb[0]));
          void'(sb.pop_front());
          rcvd++;
        end
      end
      if (c_iv && c_ir) begin
        sb.push_back(c_id);
        sent++;
      end
    end
    chk("t4_count", 32'(rcvd), 1000);
    @(negedge clock); c_iv = 1'b0;

    // Reset mid-burst on pass-through and FULL x4, then a single 0x3C beat
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      e_iv = 1'b1; e_id = 8'(8'h90 + c); e_or = 1'b0;
      d_iv = 1'b1; d_id = 8'(8'h90 + c); d_or = 1'b1;
      #1;
      if (c == 4) begin
        chk("t6_e_pre_ov", 32'(e_ov), 1);
        chk("t6_d_pass", 32'(d_od), 32'h94);
        reset = 1'b1;
      end
    end
    @(negedge clock);
    e_iv = 1'b0; d_iv = 1'b0;
    #1;
    chk("t6_e_ov", 32'(e_ov), 0);   chk("t6_e_od", 32'(e_od), 0);
    chk("t6_e_occ", 32'(e_occ), 0); chk("t6_e_ir", 32'(e_ir), 1);
    chk("t6_d_ov", 32'(d_ov), 0);   chk("t6_d_occ", 32'(d_occ), 0);
    chk("t6_d_ir", 32'(d_ir), 1);
    reset = 1'b0;
    @(negedge clock);
    e_iv = 1'b1; e_id = 8'h3C; e_or = 1'b1;
    d_iv = 1'b1; d_id = 8'h3C;
    #1;
    chk("t6_e_accept", 32'(e_ir), 1);
    chk("t6_d_ov", 32'(d_ov), 1);
    chk("t6_d_od", 32'(d_od), 32'h3C);
    chk("t6_d_hs", 32'(d_ir), 1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      e_iv = 1'b0; d_iv = 1'b0;
      #1;
      chk("t6_e_lat_ov", 32'(e_ov), 32'(c == 4));
      if (c == 4) chk("t6_e_lat_od", 32'(e_od), 32'h3C);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/register_slice_chain.md
Name: register_slice_chain

Overview:
- Parametrised chain of VALID/READY register slices, inserted on long or timing-critical streaming paths between producer and consumer blocks.
- Generalises the single half-throughput slice in four ways:
  - selectable stage depth;
  - three per-stage modes: half-throughput, forward-registered, full skid buffer;
  - synchronous flush;
  - occupancy output for debug and drain detection.

Parameters:
WIDTH_BITS, 8, payload width in bits (>=1)
STAGES, 1, number of cascaded slices (0..16); 0 = combinational pass-through
MODE, "FULL", per-stage type: "HALF", "FORWARD" or "FULL"; identical for all stages
OCC_BITS, $clog2(2*STAGES+2), occupancy width (derived localparam, not overridable)

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
flush  input  1  synchronous discard of all buffered beats
input_valid  input  1  upstream VALID
input_ready  output  1  upstream READY
input_data  input  WIDTH_BITS  upstream payload
output_valid  output  1  downstream VALID
output_ready  input  1  downstream READY
output_data  output  WIDTH_BITS  downstream payload
occupancy  output  OCC_BITS  number of beats currently held across all stages

Behaviour:
- Handshake on either side: VALID && READY at a rising edge. Payload is transferred unmodified, in order, with no loss or duplication.
- Reset (synchronous, priority over everything):
  - all stage valid bits, skid valid bits and data registers go to 0;
  - output_valid=0, output_data=0, occupancy=0;
  - input_ready after reset: 1 (HALF/FORWARD: combinational from empty state; FULL: registered, reset value 1).
- Stage k input is stage k-1 output; stage 0 input is the block input; the last stage drives the block output.
- HALF stage (1 entry):
  - in_ready = !out_valid;
  - if out_valid && out_ready then out_valid<=0;
  - if in_valid && !out_valid then out_valid<=1, data<=in_data;
  - latency 1, max throughput 1 beat / 2 cycles.
- FORWARD stage (1 entry):
  - in_ready = !out_valid || out_ready (combinational through the stage);
  - when in_ready: out_valid<=in_valid, and data<=in_data if in_valid;
  - latency 1, full throughput; ready path not registered.
- FULL stage (main + skid, 2 entries):
  - in_ready is a register = !skid_valid; no combinational path from out_ready;
  - accepted beat goes to main if main is empty or main drains this cycle, else to skid;
  - when main drains and skid is valid, skid moves to main the same edge;
  - latency 1, full throughput, back-pressure takes effect one cycle later (absorbed by skid).
- STAGES=0:
  - input_ready=output_ready && !flush; output_valid=input_valid && !flush; output_data=input_data;
  - occupancy=0; no registers.
- Flush:
  - in the flush cycle, input_ready and output_valid are forced 0, so no handshake occurs on either side;
  - at the edge, all valid and skid-valid bits clear; data registers keep their values;
  - next cycle occupancy=0, input_ready=1.
  - reset has priority over flush.
- occupancy:
  - registered; sum of all valid and skid-valid bits;
  - max STAGES (HALF/FORWARD) or 2*STAGES (FULL);
  - updated on the same edge as the state change.
- Latency: STAGES cycles from input handshake to output_valid when the pipe is empty and output_ready=1.
- Boundary conditions:
  - Full + simultaneous input and output handshake (FORWARD/FULL): occupancy unchanged.
  - output_ready deasserted mid-burst (FULL): at most one extra beat accepted per stage, into skid. No beat is overwritten.
  - Reset or flush asserted mid-burst: partially transferred beats are discarded; no spurious output_valid afterwards.
- output_valid and output_data are held stable while output_valid && !output_ready, except during flush or reset.

Test Plan:
- MODE=FULL, STAGES=2, output_ready=1, input beats 0x01..0x10 on consecutive cycles -> first output 2 cycles after first accept, 16 beats on 16 consecutive cycles, order preserved, peak occupancy=2.
- MODE=HALF, STAGES=1, input_valid held 1 with data 0xA5,0x5A, output_ready=1 -> input_ready alternates 1,0; one beat every 2 cycles.
- MODE=FULL, STAGES=2, stream running, output_ready=0 for 5 cycles -> input_ready falls after occupancy reaches 4; occupancy=4; output_data stable. On release, 4 held beats emerge in order with no gap and no loss.
- MODE=FORWARD, STAGES=3, output_ready toggled randomly, random input_valid, 1000 beats -> scoreboard matches exactly; occupancy never exceeds 3; input_ready==(!stage0_valid || stage0 downstream ready) every cycle.
- Flush with occupancy=3 (MODE=FULL, STAGES=2) -> no handshakes in the flush cycle, occupancy=0 and output_valid=0 next cycle, next accepted beat 0x77 is the next output.
- Reset asserted mid-burst, STAGES=0 and STAGES=4 -> all outputs at reset values the cycle after the reset edge. After reset release, a single beat 0x3C traverses with latency 0 and 4 respectively.
